// File: rtl/sd_arb_pkg.sv
// Shared definitions for the SD sector arbiter: FSM state codes, synchroniser
// depth and the round-robin search helper.
package sd_arb_pkg;

   localparam int SYNC_DEPTH = 2;

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] WAIT_ACK = 2'd1;
   localparam logic [1:0] XFER     = 2'd2;

   // Returns {hit, index}; the search starts one past ptr and wraps, so ptr itself is tried last.
   function automatic logic [2:0] rr_next(input logic [3:0] pend,
                                          input logic [1:0] ptr,
                                          input int unsigned n);
      logic [2:0] pick;
      logic [1:0] idx;
      pick = 3'b000;
      for (int unsigned k = 1; k <= 4; k++) begin
         idx = 2'((32'(ptr) + k) % n);
         if (k <= n && !pick[2] && pend[idx]) pick = {1'b1, idx};
      end
      return pick;
   endfunction

endpackage

// File: rtl/sd_sector_arbiter_if.sv
// Block-access port of the SPI I/O controller, shared by the sector requesters.
interface sd_sector_arbiter_if;
   logic [31:0] sd_lba;
   logic        sd_rd;
   logic        sd_wr;
   logic        sd_ack;
   logic        sd_buff_wr;
   logic [7:0]  sd_buff_din;

   modport master (
      output sd_lba, sd_rd, sd_wr, sd_buff_din,
      input  sd_ack, sd_buff_wr
   );

   modport slave (
      input  sd_lba, sd_rd, sd_wr, sd_buff_din,
      output sd_ack, sd_buff_wr
   );
endinterface

// File: rtl/sd_ack_sync.sv
// Brings an SPI-domain handshake level into clk_sys and emits one-cycle
// rise/fall pulses on the synchronised level.
module sd_ack_sync
   import sd_arb_pkg::*;
(
   input  logic clk_sys,
   input  logic reset,
   input  logic ack_async,
   output logic ack_rise,
   output logic ack_fall
);

   logic [SYNC_DEPTH-1:0] sync_q;
   logic                  ack_s;
   logic                  ack_d;

   assign ack_s = sync_q[SYNC_DEPTH-1];

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         ack_d  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_DEPTH-2:0], ack_async};
         ack_d  <= ack_s;
      end
   end

   assign ack_rise = ack_s & ~ack_d;
   assign ack_fall = ~ack_s & ack_d;

endmodule

// File: rtl/sd_sector_arbiter.sv
// Round-robin arbiter sharing the SD sector port between NREQ requesters,
// one sector per grant, with buffer strobe/data routed to the owner only.
module sd_sector_arbiter
   import sd_arb_pkg::*;
#(
   parameter int          NREQ    = 2,
   parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
   input  logic                clk_sys,
   input  logic                reset,
   input  logic [32*NREQ-1:0]  req_lba,
   input  logic [NREQ-1:0]     req_rd,
   input  logic [NREQ-1:0]     req_wr,
   output logic [NREQ-1:0]     req_busy,
   output logic [NREQ-1:0]     req_done,
   output logic [NREQ-1:0]     req_err,
   output logic [NREQ-1:0]     req_buff_wr,
   input  logic [8*NREQ-1:0]   req_buff_din,
   sd_sector_arbiter_if.master sd
);

   localparam int IDX_W = (NREQ > 2) ? 2 : 1;

   logic [1:0]       state;
   logic [IDX_W-1:0] owner;
   logic [IDX_W-1:0] rr_ptr;
   logic [23:0]      timer;
   logic [NREQ-1:0]  pend;
   logic [NREQ-1:0]  dir_q;
   logic [31:0]      lba_q [NREQ];
   logic [31:0]      sd_lba_q;
   logic             sd_rd_q;
   logic             sd_wr_q;

   logic             ack_rise;
   logic             ack_fall;
   logic [2:0]       rr_pick;
   logic             grant;
   logic [IDX_W-1:0] grant_idx;
   logic [NREQ-1:0]  grant_oh;
   logic [NREQ-1:0]  owner_oh;
   logic [NREQ-1:0]  accept;
   logic [31:0]      grant_lba;
   logic             grant_dir;
   logic [7:0]       owner_din;

   sd_ack_sync u_ack_sync (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .ack_async (sd.sd_ack),
      .ack_rise  (ack_rise),
      .ack_fall  (ack_fall)
   );

   assign rr_pick   = rr_next(4'(pend), 2'(rr_ptr), NREQ);
   assign grant     = (state == IDLE) && rr_pick[2];
   assign grant_idx = IDX_W'(rr_pick[1:0]);

   always_comb begin
      owner_oh = '0;
      owner_oh[owner] = 1'b1;
      grant_oh = '0;
      grant_oh[grant_idx] = grant;
      grant_lba = '0;
      grant_dir = 1'b0;
      owner_din = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_oh[i]) begin
            grant_lba = lba_q[i];
            grant_dir = dir_q[i];
         end
         if (owner_oh[i]) owner_din = req_buff_din[8*i +: 8];
      end
   end

   // Pulses are dropped while the requester is already queued or owns the port.
   assign req_busy = pend | ((state != IDLE) ? owner_oh : '0);
   assign accept   = (req_rd | req_wr) & ~req_busy;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) pend <= '0;
      else       pend <= (pend | accept) & ~grant_oh;
   end

   // Captured address/direction are only read after pend is set, so no reset is needed.
   always_ff @(posedge clk_sys) begin
      for (int i = 0; i < NREQ; i++) begin
         if (accept[i]) begin
            lba_q[i] <= req_lba[32*i +: 32];
            dir_q[i] <= req_wr[i];
         end
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         owner    <= '0;
         rr_ptr   <= '0;
         timer    <= '0;
         sd_lba_q <= '0;
         sd_rd_q  <= 1'b0;
         sd_wr_q  <= 1'b0;
         req_done <= '0;
         req_err  <= '0;
      end else begin
         req_done <= '0;
         req_err  <= '0;
         case (state)
            IDLE: begin
               if (grant) begin
                  owner    <= grant_idx;
                  rr_ptr   <= grant_idx;
                  sd_lba_q <= grant_lba;
                  sd_rd_q  <= ~grant_dir;
                  sd_wr_q  <= grant_dir;
                  timer    <= '0;
                  state    <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (ack_rise) begin
                  sd_rd_q <= 1'b0;
                  sd_wr_q <= 1'b0;
                  state   <= XFER;
               end else if (timer == TIMEOUT - 24'd1) begin
                  sd_rd_q <= 1'b0;
                  sd_wr_q <= 1'b0;
                  req_err <= owner_oh;
                  state   <= IDLE;
               end else begin
                  timer <= timer + 24'd1;
               end
            end
            XFER: begin
               // The I/O block bounds the transfer, so only ack_fall ends it.
               if (ack_fall) begin
                  req_done <= owner_oh;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign sd.sd_lba      = sd_lba_q;
   assign sd.sd_rd       = sd_rd_q;
   assign sd.sd_wr       = sd_wr_q;
   assign sd.sd_buff_din = (state != IDLE) ? owner_din : 8'h00;
   assign req_buff_wr    = ((state == XFER) && sd.sd_buff_wr) ? owner_oh : '0;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Scoreboard bench for sd_sector_arbiter: grants and completions are queued
// when requests are issued and checked as the arbiter produces them.
module tb_sd_sector_arbiter;

   localparam int NREQ = 2;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic [63:0] req_lba;
   logic [1:0]  req_rd;
   logic [1:0]  req_wr;
   logic [1:0]  req_busy;
   logic [1:0]  req_done;
   logic [1:0]  req_err;
   logic [1:0]  req_buff_wr;
   logic [15:0] req_buff_din;

   sd_sector_arbiter_if sd ();

   sd_sector_arbiter #(.NREQ(NREQ), .TIMEOUT(24'd100)) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .req_lba      (req_lba),
      .req_rd       (req_rd),
      .req_wr       (req_wr),
      .req_busy     (req_busy),
      .req_done     (req_done),
      .req_err      (req_err),
      .req_buff_wr  (req_buff_wr),
      .req_buff_din (req_buff_din),
      .sd           (sd)
   );

   always #5 clk_sys = ~clk_sys;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic        wr;
      logic [31:0] lba;
   } grant_t;

   grant_t     gq[$];
   logic [3:0] cq[$];
   grant_t     mon_g;
   logic [3:0] mon_c;
   logic       strobe_q = 1'b0;

   always @(negedge clk_sys) begin
      if (!reset) begin
         if ((sd.sd_rd || sd.sd_wr) && !strobe_q) begin
            if (gq.size() == 0) check_eq("grant_unexpected", 1, 0);
            else begin
               mon_g = gq.pop_front();
               check_eq("grant_lba", sd.sd_lba, mon_g.lba);
               check_eq("grant_dir", {sd.sd_wr, sd.sd_rd}, {mon_g.wr, ~mon_g.wr});
            end
         end
         if ((req_done | req_err) != 2'b00) begin
            if (cq.size() == 0) check_eq("cmpl_unexpected", {req_err, req_done}, 0);
            else begin
               mon_c = cq.pop_front();
               check_eq("cmpl", {req_err, req_done}, mon_c);
            end
         end
      end
      strobe_q <= sd.sd_rd | sd.sd_wr;
   end

   task automatic io_serve(input int nbytes, input int owner, input logic [7:0] din_exp);
      int t;
      int ok_wr;
      int ok_din;
      t = 0;
      while (!(sd.sd_rd || sd.sd_wr) && t < 200) begin
         @(negedge clk_sys);
         t++;
      end
      check_eq("io_grant_seen", (t < 200), 1);
      check_eq("io_din_wait_ack", sd.sd_buff_din, din_exp);
      sd.sd_ack = 1'b1;
      t = 0;
      while ((sd.sd_rd || sd.sd_wr) && t < 10) begin
         @(negedge clk_sys);
         t++;
      end
      check_eq("io_strobe_drop_cycles", t, 3);
      ok_wr  = 0;
      ok_din = 0;
      for (int k = 0; k < nbytes; k++) begin
         @(negedge clk_sys);
         sd.sd_buff_wr = 1'b1;
         #1;
         if (req_buff_wr == (2'b01 << owner)) ok_wr++;
         if (sd.sd_buff_din == din_exp) ok_din++;
         @(negedge clk_sys);
         sd.sd_buff_wr = 1'b0;
         #1;
         if (req_buff_wr == 2'b00) ok_wr++;
      end
      check_eq("io_buff_wr_route", ok_wr, 2 * nbytes);
      check_eq("io_buff_din", ok_din, nbytes);
      @(negedge clk_sys);
      sd.sd_ack = 1'b0;
      repeat (5) @(negedge clk_sys);
   endtask

   task automatic pulse(input logic [1:0] rd, input logic [1:0] wr);
      req_rd = rd;
      req_wr = wr;
      @(negedge clk_sys);
      req_rd = 2'b00;
      req_wr = 2'b00;
   endtask

   int t;
   int cyc;

   initial begin
      reset         = 1'b1;
      req_rd        = '0;
      req_wr        = '0;
      req_lba       = '0;
      req_buff_din  = '0;
      sd.sd_ack     = 1'b0;
      sd.sd_buff_wr = 1'b0;
      repeat (3) @(negedge clk_sys);
      check_eq("reset_outputs",
               {sd.sd_rd, sd.sd_wr, sd.sd_lba, sd.sd_buff_din, req_busy, req_done, req_err, req_buff_wr}, 0);
      reset = 1'b0;
      @(negedge clk_sys);

      // single read, 512 bytes
      req_lba[31:0] = 32'h0000_1234;
      gq.push_back('{1'b0, 32'h0000_1234});
      cq.push_back(4'b0001);
      pulse(2'b01, 2'b00);
      check_eq("t1_busy_after_capture", req_busy, 2'b01);
      check_eq("t1_rd_not_yet", sd.sd_rd, 0);
      @(negedge clk_sys);
      check_eq("t1_rd_after_2", sd.sd_rd, 1);
      io_serve(512, 0, 8'h00);

      // contention plus per-owner data path
      req_lba      = {32'h0000_3001, 32'h0000_2000};
      req_buff_din = {8'hA5, 8'h5A};
      gq.push_back('{1'b1, 32'h0000_3001});
      gq.push_back('{1'b0, 32'h0000_2000});
      cq.push_back(4'b0010);
      cq.push_back(4'b0001);
      pulse(2'b01, 2'b10);
      io_serve(8, 1, 8'hA5);
      io_serve(8, 0, 8'h5A);

      // timeout on requester 1, then requester 0 served
      req_lba = {32'h0000_4101, 32'h0000_4000};
      gq.push_back('{1'b0, 32'h0000_4101});
      gq.push_back('{1'b0, 32'h0000_4000});
      cq.push_back(4'b1000);
      cq.push_back(4'b0001);
      pulse(2'b11, 2'b00);
      t = 0;
      while (!(sd.sd_rd || sd.sd_wr) && t < 20) begin
         @(negedge clk_sys);
         t++;
      end
      check_eq("t4_grant_seen", (t < 20), 1);
      cyc = 0;
      while (req_err == 2'b00 && cyc < 150) begin
         @(negedge clk_sys);
         cyc++;
      end
      check_eq("t4_err_latency", cyc, 100);
      check_eq("t4_rd_dropped", sd.sd_rd, 0);
      io_serve(2, 0, 8'h5A);

      // both pulses together give a write; repeats while busy are ignored
      req_lba[31:0] = 32'h0000_5000;
      gq.push_back('{1'b1, 32'h0000_5000});
      cq.push_back(4'b0001);
      pulse(2'b01, 2'b01);
      req_lba[31:0] = 32'h0000_5555;
      pulse(2'b01, 2'b00);
      pulse(2'b01, 2'b00);
      io_serve(4, 0, 8'h5A);
      repeat (10) @(negedge clk_sys);
      check_eq("t5_idle_busy", req_busy, 2'b00);

      // reset in the middle of a transfer
      req_lba[63:32] = 32'h0000_6001;
      gq.push_back('{1'b0, 32'h0000_6001});
      cq.push_back(4'b0010);
      pulse(2'b10, 2'b00);
      t = 0;
      while (!(sd.sd_rd || sd.sd_wr) && t < 20) begin
         @(negedge clk_sys);
         t++;
      end
      sd.sd_ack = 1'b1;
      t = 0;
      while ((sd.sd_rd || sd.sd_wr) && t < 10) begin
         @(negedge clk_sys);
         t++;
      end
      @(negedge clk_sys);
      sd.sd_buff_wr = 1'b1;
      #1;
      check_eq("t6_xfer_route", req_buff_wr, 2'b10);
      reset = 1'b1;
      #1;
      check_eq("t6_reset_outputs",
               {sd.sd_rd, sd.sd_wr, sd.sd_lba, sd.sd_buff_din, req_busy, req_done, req_err, req_buff_wr}, 0);
      cq.delete();
      sd.sd_buff_wr = 1'b0;
      sd.sd_ack     = 1'b0;
      repeat (3) @(negedge clk_sys);
      reset = 1'b0;
      @(negedge clk_sys);
      check_eq("t6_busy_after_reset", req_busy, 2'b00);
      req_lba[31:0] = 32'h0000_7000;
      gq.push_back('{1'b0, 32'h0000_7000});
      cq.push_back(4'b0001);
      pulse(2'b01, 2'b00);
      io_serve(4, 0, 8'h5A);

      check_eq("grant_queue_drained", gq.size(), 0);
      check_eq("cmpl_queue_drained", cq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sd_sector_arbiter.md
Name: sd_sector_arbiter

Overview:
- Shares the single SD block-access port of the SPI I/O controller (sd_lba, sd_rd, sd_wr, sd_ack, sd_buff_*) between NREQ independent sector requesters, e.g. floppy controller and disk-image loader.
- Requests are captured as pulses and granted round-robin, one sector at a time.
- During a granted transfer, the buffer write strobe and read data are routed to the owning requester only.
- Sits in the clk_sys domain between the core's disk controllers and the SPI I/O block.

Parameters:
- NREQ, 2, number of requesters (2..4).
- TIMEOUT, 24'd10_000_000, clk_sys cycles to wait for sd_ack rise before aborting a grant.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_lba  in  32*NREQ  packed sector addresses; requester i uses [32*i+:32]. Sampled on the req_rd/req_wr pulse.
- req_rd  in  NREQ  one-cycle read-sector request pulses.
- req_wr  in  NREQ  one-cycle write-sector request pulses.
- req_busy  out  NREQ  requester i has a pending or active request.
- req_done  out  NREQ  one-cycle pulse; sector finished OK.
- req_err  out  NREQ  one-cycle pulse; sector aborted on timeout.
- req_buff_wr  out  NREQ  gated copy of sd_buff_wr for the owner.
- req_buff_din  in  8*NREQ  per-requester buffer read data.
- sd_lba  out  32  to the I/O block.
- sd_rd  out  1  to the I/O block.
- sd_wr  out  1  to the I/O block.
- sd_ack  in  1  from the I/O block (SPI_SCK domain, asynchronous).
- sd_buff_wr  in  1  from the I/O block.
- sd_buff_din  out  8  to the I/O block; muxed from the owner.

Behaviour:
- Reset values: all outputs 0; internal state IDLE; pending bits 0; rr_ptr 0.
- Capture: a req_rd[i] or req_wr[i] pulse sets pend[i] and latches lba[i] and dir[i] (1 = write).
  - If both pulses arrive in the same cycle, write wins.
  - A pulse while pend[i] or while i owns the port is ignored.
  - req_busy[i] = pend[i] | (owner == i && state != IDLE).
- sd_ack passes through a 2-flop synchroniser (ack_s). An edge detector on ack_s yields ack_rise and ack_fall.
- IDLE:
  - Search pend starting at rr_ptr+1 mod NREQ, wrapping; pick the first set bit.
  - On a hit: owner <= i, clear pend[i], rr_ptr <= i, drive sd_lba = lba[i], assert sd_rd or sd_wr per dir[i], clear the timer, go to WAIT_ACK.
- WAIT_ACK:
  - sd_rd/sd_wr stay high. The timer increments each cycle.
  - ack_rise: drop sd_rd/sd_wr, go to XFER.
  - Timer reaches TIMEOUT-1: drop strobes, pulse req_err[owner], go to IDLE.
- XFER:
  - req_buff_wr[owner] = sd_buff_wr, combinational. All other bits are 0.
  - sd_buff_din = req_buff_din[owner] in XFER and WAIT_ACK; 0 in IDLE.
  - ack_fall: pulse req_done[owner], go to IDLE.
  - No timeout in XFER; the transfer is bounded by the I/O block.
- sd_lba holds its value from grant until the next grant.
- Back-to-back: the next grant occurs no earlier than the cycle after DONE. New pulses arriving during XFER are queued as pend.
- Latency: request pulse to sd_rd high is 2 clk_sys cycles when idle (capture cycle, then grant cycle).
- reset asserted mid-transfer: strobes drop immediately and all pend bits are lost. No done/err pulse is generated.
- Round-robin guarantees that no requester waits more than NREQ-1 grants.

Decomposition:
- Shared package sd_arb_pkg holds:
  - state enum {IDLE, WAIT_ACK, XFER};
  - the round-robin next-index function;
  - localparam for the sync depth (2).
- Sub-module sd_ack_sync: 2-flop synchroniser plus rise/fall pulse generator. It is reusable by other SPI-domain handshakes.

Test Plan:
1. Single read: req_rd[0] pulse with req_lba[31:0]=32'h0000_1234.
   - sd_rd rises 2 cycles later with sd_lba=32'h1234.
   - On ack high: sd_rd drops within 3 cycles.
   - 512 sd_buff_wr pulses appear only on req_buff_wr[0].
   - On ack low: req_done[0] pulses once.
2. Contention: req_rd[0] and req_wr[1] pulse in the same cycle, rr_ptr=0.
   - Requester 1 is granted first (sd_wr=1, lba1).
   - After its done, requester 0 is granted with sd_rd=1.
3. Write data path: requester 1 writes with req_buff_din[15:8]=8'hA5 during the grant.
   - sd_buff_din=8'hA5 throughout; req_buff_wr[0] stays 0.
4. Timeout: TIMEOUT=100, sd_ack held 0.
   - req_err[owner] pulses 100 cycles after grant; sd_rd=0.
   - The next pending requester is granted.
5. Duplicate/both pulses:
   - req_rd[0] and req_wr[0] in the same cycle produce a write.
   - A second req_rd[0] while busy is ignored: exactly one req_done.
6. Reset mid-XFER: assert reset with sd_ack=1.
   - All outputs 0 asynchronously and req_busy=0.
   - After release, the block is IDLE and accepts a new request.
